ram_frame_latch: RTL and testbench

RAM_FRAME_LATCH -- requirements
Module: ram_frame_latch

---
 rtl/ram_frame_latch.sv | 149 ++++++++++++++
 tb/tb_ram_frame_latch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_frame_latch.sv
// Latches a DEPTH-byte frame out of a data RAM into a display buffer on each vsync.
// Define FRAME_LATCH_DBUF_EN for tear-free double buffering; default is a single in-place buffer.
module ram_frame_latch #(
  parameter int DEPTH = 65,
  parameter int AW    = 7,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic [AW-1:0] pix_addr,
  output logic [DW-1:0] pix_data,
  output logic [DW-1:0] disp_byte,
  output logic          frame_valid,
  output logic          busy,
  output logic          copy_done,
  output logic          overrun,
  input  logic          ovr_clr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, COPY, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          copy_done_q, copy_done_d;
  logic          overrun_q, overrun_d;
  logic          frame_valid_q, frame_valid_d;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
`ifdef FRAME_LATCH_DBUF_EN
  logic          sel_q, sel_d;
  logic          swap_pend_q, swap_pend_d;
  logic [DW-1:0] mem_q [2][DEPTH];
`else
  logic [DW-1:0] mem_q [DEPTH];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_addr_q     <= '0;
      copy_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
`ifdef FRAME_LATCH_DBUF_EN
      sel_q         <= 1'b0;
      swap_pend_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      copy_done_q   <= copy_done_d;
      overrun_q     <= overrun_d;
      frame_valid_q <= frame_valid_d;
      // RAM data lags the issued address by one cycle, so the write port trails the read port.
      wr_en_q       <= (state_q == COPY);
      wr_addr_q     <= rd_addr_q;
`ifdef FRAME_LATCH_DBUF_EN
      sel_q         <= sel_d;
      swap_pend_q   <= swap_pend_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    copy_done_d   = 1'b0;
    overrun_d     = ovr_clr ? 1'b0 : overrun_q;
    frame_valid_d = frame_valid_q;
`ifdef FRAME_LATCH_DBUF_EN
    sel_d         = sel_q;
    swap_pend_d   = swap_pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        rd_addr_d = '0;
        if (frame_start) begin
          state_d = COPY;
`ifdef FRAME_LATCH_DBUF_EN
          if (swap_pend_q) begin
            sel_d         = ~sel_q;
            swap_pend_d   = 1'b0;
            frame_valid_d = 1'b1;
          end
`endif
        end
      end
      COPY: begin
        if (frame_start) overrun_d = 1'b1;
        if (rd_addr_q == LAST_ADDR) begin
          state_d   = DRAIN;
          rd_addr_d = '0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (frame_start) overrun_d = 1'b1;
        state_d     = IDLE;
        copy_done_d = 1'b1;
`ifdef FRAME_LATCH_DBUF_EN
        swap_pend_d = 1'b1;
`else
        frame_valid_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
`ifdef FRAME_LATCH_DBUF_EN
    if (wr_en_q) mem_q[~sel_q][wr_addr_q] <= rd_data;
`else
    if (wr_en_q) mem_q[wr_addr_q] <= rd_data;
`endif
  end

  always_comb begin
    pix_data  = '0;
    disp_byte = '0;
    if (frame_valid_q) begin
`ifdef FRAME_LATCH_DBUF_EN
      if ({1'b0, pix_addr} < DEPTH_X) pix_data = mem_q[sel_q][pix_addr];
      disp_byte = mem_q[sel_q][DEPTH-1];
`else
      if ({1'b0, pix_addr} < DEPTH_X) pix_data = mem_q[pix_addr];
      disp_byte = mem_q[DEPTH-1];
`endif
    end
  end

  assign rd_en       = (state_q == COPY);
  assign rd_addr     = rd_addr_q;
  assign busy        = (state_q != IDLE);
  assign copy_done   = copy_done_q;
  assign overrun     = overrun_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_ram_frame_latch.sv
// Directed scoreboard bench for ram_frame_latch; expectations follow FRAME_LATCH_DBUF_EN when defined.
module tb_ram_frame_latch;
  localparam int DEPTH = 65;
  localparam int AW    = 7;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset, frame_start, ovr_clr;
  logic          rd_en, frame_valid, busy, copy_done, overrun;
  logic [AW-1:0] rd_addr, pix_addr;
  logic [DW-1:0] rd_data, pix_data, disp_byte;
  logic [DW-1:0] ram [2**AW];

  int tests = 0;
  int fails = 0;
  int addr_q[$];
  int pix_q[$];

  ram_frame_latch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_addr(pix_addr), .pix_data(pix_data), .disp_byte(disp_byte),
    .frame_valid(frame_valid), .busy(busy), .copy_done(copy_done),
    .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  function automatic logic [DW-1:0] exp_byte(input int mode, input int i);
    case (mode)
      0:       return DW'(i + 1);
      1:       return DW'(3 * i + 7);
      2:       return DW'(255 - i);
      default: return DW'(i ^ 'h5A);
    endcase
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 2**AW; i++) ram[i] = exp_byte(mode, i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix_chk(input int a, input int exp);
    pix_addr = AW'(a);
    pix_q.push_back(exp);
    #1;
    chk($sformatf("pix[%0d]", a), {24'd0, pix_data}, pix_q.pop_front());
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_rd_en"},     {31'd0, rd_en},       0);
    chk({p, "_rd_addr"},   {25'd0, rd_addr},     0);
    chk({p, "_busy"},      {31'd0, busy},        0);
    chk({p, "_copy_done"}, {31'd0, copy_done},   0);
    chk({p, "_overrun"},   {31'd0, overrun},     0);
    chk({p, "_fvalid"},    {31'd0, frame_valid}, 0);
    chk({p, "_disp"},      {24'd0, disp_byte},   0);
    pix_chk(5, 0);
  endtask

  // Starts a copy and follows it to the copy_done cycle (returns there, without ticking).
  task automatic run_copy(input int inject_at, input bit clr_with, input int abort_at);
    frame_start = 1'b1;
    for (int a = 0; a < DEPTH; a++) addr_q.push_back(a);
    tick();
    frame_start = 1'b0;
    ovr_clr     = 1'b0;
    for (int k = 0; k <= DEPTH + 1; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        addr_q.delete();
        reset_checks("abort");
        return;
      end
      chk($sformatf("busy@%0d", k),      {31'd0, busy},      32'(k <= DEPTH));
      chk($sformatf("copy_done@%0d", k), {31'd0, copy_done}, 32'(k == DEPTH + 1));
      chk($sformatf("rd_en@%0d", k),     {31'd0, rd_en},     32'(k < DEPTH));
      if (rd_en && addr_q.size() > 0)
        chk($sformatf("rd_addr@%0d", k), {25'd0, rd_addr}, addr_q.pop_front());
      if (k == DEPTH + 1) chk("rd_addr_idle", {25'd0, rd_addr}, 0);
      if (k == inject_at) begin
        frame_start = 1'b1;
        ovr_clr     = clr_with;
      end else if (k == inject_at + 1) begin
        frame_start = 1'b0;
        ovr_clr     = 1'b0;
      end
      if (k < DEPTH + 1) tick();
    end
    chk("addr_left", addr_q.size(), 0);
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    ovr_clr     = 1'b0;
    pix_addr    = '0;
    fill(0);
    tick();
    tick();
    reset_checks("rst");
    reset = 1'b0;
    repeat (3) tick();

    // Frame A: RAM[i] = i+1
    run_copy(-1, 1'b0, -1);
    chk("ovr_A", {31'd0, overrun}, 0);
    tick();
`ifdef FRAME_LATCH_DBUF_EN
    chk("fvalid_A", {31'd0, frame_valid}, 0);
    chk("disp_A",   {24'd0, disp_byte},   0);
    pix_chk(5, 0);
`else
    chk("fvalid_A", {31'd0, frame_valid}, 1);
    chk("disp_A",   {24'd0, disp_byte},   65);
    pix_chk(5, 6);
    pix_chk(64, 65);
    pix_chk(0, 1);
    pix_chk(65, 0);
`endif

    // Frame B with an ignored frame_start mid-copy
    fill(1);
    run_copy(30, 1'b0, -1);
    chk("ovr_B", {31'd0, overrun}, 1);
    tick();
    chk("fvalid_B", {31'd0, frame_valid}, 1);
`ifdef FRAME_LATCH_DBUF_EN
    chk("disp_B", {24'd0, disp_byte}, 65);
    pix_chk(5, 6);
    pix_chk(64, 65);
`else
    chk("disp_B", {24'd0, disp_byte}, 32'(exp_byte(1, 64)));
    pix_chk(5, 22);
    pix_chk(64, 199);
`endif

    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 0);

    // Frame C: clear and new overrun in the same cycle
    fill(2);
    run_copy(20, 1'b1, -1);
    chk("ovr_set_wins", {31'd0, overrun}, 1);

    // Frame D starts in C's copy_done cycle
    ovr_clr = 1'b1;
    run_copy(-1, 1'b0, -1);
    chk("ovr_coinc", {31'd0, overrun}, 0);
    tick();
    chk("disp_D", {24'd0, disp_byte}, 32'(exp_byte(2, 64)));
    pix_chk(100, 0);
    pix_chk(64, 191);
    pix_chk(0, 255);

    // Frame E abandoned by reset mid-copy
    fill(3);
    run_copy(-1, 1'b0, 40);
    reset = 1'b0;
    repeat (3) tick();
    chk("fvalid_after_abort", {31'd0, frame_valid}, 0);
    chk("busy_after_abort",   {31'd0, busy},        0);
    pix_chk(5, 0);

    // Frame F after recovery
    fill(0);
    run_copy(-1, 1'b0, -1);
    tick();
`ifdef FRAME_LATCH_DBUF_EN
    chk("fvalid_F", {31'd0, frame_valid}, 0);
`else
    chk("fvalid_F", {31'd0, frame_valid}, 1);
    pix_chk(7, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
